// File: rtl/bram_fifo_pkg.sv
// Shared types and helpers for the block-RAM backed streaming FIFO.
package bram_fifo_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    // Explicit wrap keeps the helper correct even if depth were not a power of 2.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/bram_fifo_ctrl_if.sv
// Producer/consumer stream bundle of the FIFO controller.
interface bram_fifo_ctrl_if #(
    parameter int W = 8,
    parameter int D = 128
);
    localparam int CW = $clog2(D + 3);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] count;
    logic          empty;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, empty
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, empty
    );
endinterface

// File: rtl/fifo_skid2.sv
// Two-entry register FIFO that absorbs RAM read data and presents the stream head.
module fifo_skid2
    import bram_fifo_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    input  logic [W-1:0] s_data_i,
    output logic         m_valid_o,
    input  logic         m_ready_i,
    output logic [W-1:0] m_data_o,
    output occ_t         occ_o
);
    occ_t         occ_q, occ_d;
    logic [W-1:0] head_q, head_d, tail_q, tail_d;
    logic         take, give;

    assign m_valid_o = (occ_q != OCC_EMPTY);
    assign s_ready_o = (occ_q != OCC_TWO) || m_ready_i;
    assign m_data_o  = head_q;
    assign occ_o     = occ_q;
    assign take      = s_valid_i & s_ready_o;
    assign give      = m_valid_o & m_ready_i;

    // The head register is left untouched when the stage drains, so out_data holds its last word.
    always_comb begin
        // NOTE: defaults first so every path assigns every _d signal and no latch is inferred.
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case (occ_q)
            OCC_EMPTY: if (take) begin
                head_d = s_data_i;
                occ_d  = OCC_ONE;
            end
            OCC_ONE: unique case ({take, give})
                2'b10: begin tail_d = s_data_i; occ_d = OCC_TWO;   end
                2'b01: begin                    occ_d = OCC_EMPTY; end
                2'b11: begin head_d = s_data_i;                    end
                default: ;
            endcase
            OCC_TWO: if (give) begin
                head_d = tail_q;
                if (take) tail_d = s_data_i;
                else      occ_d  = OCC_ONE;
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end
endmodule

// File: rtl/mem2p_sw_sr.sv
// Two-port block RAM: synchronous write on port 1, registered read on port 2.
module mem2p_sw_sr #(
    parameter int W = 8,
    parameter int D = 128
) (
    input  logic                 clk,
    input  logic                 we1,
    input  logic [$clog2(D)-1:0] addr1,
    input  logic [W-1:0]         din1,
    input  logic                 re2,
    input  logic [$clog2(D)-1:0] addr2,
    output logic [W-1:0]         dout2
);
    logic [W-1:0] mem [D];

    // NOTE: no reset on the array or read register, so the tools can map it onto block RAM.
    always_ff @(posedge clk) begin
        if (we1) mem[addr1] <= din1;
        if (re2) dout2 <= mem[addr2];
    end
endmodule

// File: rtl/bram_fifo_ctrl.sv
// Valid/ready FIFO built on mem2p_sw_sr, with a 2-entry prefetch stage hiding the read latency.
module bram_fifo_ctrl
    import bram_fifo_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 128
) (
    input logic              clk,
    input logic              rst,
    bram_fifo_ctrl_if.slave  bus
);
    localparam int AW = $clog2(D);
    localparam int CW = $clog2(D + 3);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   mem_cnt_q, mem_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic          inflight_q, inflight_d;

    logic          in_ready, push, pop, issue, cap_ready, stage_valid;
    logic [W-1:0]  dout2;
    logic [2:0]    pipe_occ;
    occ_t          occ;

    // Registered state only: no combinational path from in_valid or out_ready.
    assign in_ready = (mem_cnt_q != (AW + 1)'(D));
    assign push     = bus.in_valid & in_ready;
    assign pop      = stage_valid & bus.out_ready;

    // Words already committed downstream of the RAM: stage entries plus the read in flight.
    assign pipe_occ = {1'b0, occ} + {2'b00, inflight_q};
    assign issue    = (mem_cnt_q != '0) && (pipe_occ < (3'd2 + {2'b00, pop}));

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_cnt_d  = mem_cnt_q;
        count_d    = count_q;
        inflight_d = issue;
        if (push)  wr_ptr_d = AW'(ptr_inc(32'(wr_ptr_q), D));
        if (issue) rd_ptr_d = AW'(ptr_inc(32'(rd_ptr_q), D));
        unique case ({push, issue})
            2'b10:   mem_cnt_d = mem_cnt_q + 1'b1;
            2'b01:   mem_cnt_d = mem_cnt_q - 1'b1;
            default: ;
        endcase
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

    mem2p_sw_sr #(.W(W), .D(D)) u_mem (
        .clk   (clk),
        .we1   (push),
        .addr1 (wr_ptr_q),
        .din1  (bus.in_data),
        .re2   (issue),
        .addr2 (rd_ptr_q),
        .dout2 (dout2)
    );

    fifo_skid2 #(.W(W)) u_stage (
        .clk       (clk),
        .rst       (rst),
        .s_valid_i (inflight_q),
        .s_ready_o (cap_ready),
        .s_data_i  (dout2),
        .m_valid_o (stage_valid),
        .m_ready_i (bus.out_ready),
        .m_data_o  (bus.out_data),
        .occ_o     (occ)
    );

    // The issue rule reserves a stage slot, so returning read data is never refused.
    capture_never_blocked: assert property (@(posedge clk) disable iff (rst) inflight_q |-> cap_ready);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = stage_valid;
    assign bus.count     = count_q;
    assign bus.empty     = (count_q == '0);
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Self-checking bench for bram_fifo_ctrl against a queue-based reference model.
module tb_bram_fifo_ctrl;
    localparam int W = 8;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bram_fifo_ctrl_if #(.W(W), .D(D)) bus ();
    bram_fifo_ctrl #(.W(W), .D(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] model_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // One clock cycle: drive inputs after the falling edge, check the cycle state, advance the model.
    task automatic drive_cycle(input logic iv, input logic [W-1:0] id, input logic ordy,
                               output logic pushed, output logic popped);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        #1;
        pushed = iv & bus.in_ready;
        popped = bus.out_valid & ordy;
        check("count", 32'(bus.count), 32'(model_q.size()));
        check("empty", 32'(bus.empty), 32'(model_q.size() == 0));
        if (model_q.size() == 0) check("ov_when_empty", 32'(bus.out_valid), 32'd0);
        if (model_q.size() < D) check("in_ready_room", 32'(bus.in_ready), 32'd1);
        if (model_q.size() == D + 2) check("in_ready_full", 32'(bus.in_ready), 32'd0);
        if (popped && model_q.size() != 0) begin
            check("pop_data", 32'(bus.out_data), 32'(model_q[0]));
            void'(model_q.pop_front());
        end
        if (pushed) model_q.push_back(id);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hEE;
        bus.out_ready = 1'b0;
        repeat (cycles) @(negedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        model_q.delete();
    endtask

    task automatic single_word(input logic [W-1:0] d);
        logic pu, po;
        drive_cycle(1'b1, d, 1'b0, pu, po);
        check("sw_push", 32'(pu), 32'd1);
        drive_cycle(1'b0, '0, 1'b0, pu, po);
        check("sw_lat_t1", 32'(bus.out_valid), 32'd0);
        drive_cycle(1'b0, '0, 1'b0, pu, po);
        check("sw_lat_t2", 32'(bus.out_valid), 32'd0);
        drive_cycle(1'b0, '0, 1'b1, pu, po);
        check("sw_lat_t3", 32'(bus.out_valid), 32'd1);
        check("sw_data", 32'(bus.out_data), 32'(d));
        drive_cycle(1'b0, '0, 1'b0, pu, po);
        check("sw_empty_after", 32'(bus.empty), 32'd1);
        check("sw_hold_data", 32'(bus.out_data), 32'(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic pu, po, a;
        int   k, pops, gaps;
        bit   started;

        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset held two cycles with a producer offering data.
        do_reset(2);
        drive_cycle(1'b0, '0, 1'b0, pu, po);

        single_word(8'hA5);

        // Fill to capacity with the consumer stalled, then drain in order.
        k = 1;
        for (int c = 0; c < 12; c++) begin
            drive_cycle(1'b1, 8'(k), 1'b0, pu, po);
            if (pu) k++;
        end
        check("fill_count", 32'(bus.count), 32'(D + 2));
        check("fill_in_ready", 32'(bus.in_ready), 32'd0);
        check("fill_held_word", 32'(k), 32'd7);
        pops = 0;
        for (int c = 0; c < 40 && (model_q.size() != 0 || k <= 7); c++) begin
            drive_cycle(k <= 7, 8'(k), 1'b1, pu, po);
            if (pu) k++;
            if (po) pops++;
        end
        check("fill_drained", 32'(model_q.size()), 32'd0);
        check("fill_pops", 32'(pops), 32'd7);

        // Continuous streaming: after the first pop, one pop every cycle.
        k = 0; pops = 0; gaps = 0; started = 1'b0;
        for (int c = 0; c < 60 && pops < 20; c++) begin
            drive_cycle(k < 20, 8'(8'h40 + k), 1'b1, pu, po);
            if (pu) k++;
            if (po) begin
                pops++;
                started = 1'b1;
            end else if (started) begin
                gaps++;
            end
        end
        check("stream_pops", 32'(pops), 32'd20);
        check("stream_gaps", 32'(gaps), 32'd0);

        // Random traffic with varying backpressure; in_ready must ignore same-cycle inputs.
        for (int c = 0; c < 1000; c++) begin
            drive_cycle(1'($urandom_range(0, 3) != 0), 8'($urandom),
                        (c < 500) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 3) == 0), pu, po);
            a = bus.in_ready;
            bus.out_ready = ~bus.out_ready;
            bus.in_valid  = ~bus.in_valid;
            #1;
            check("in_ready_indep", 32'(bus.in_ready), 32'(a));
            bus.out_ready = ~bus.out_ready;
            bus.in_valid  = ~bus.in_valid;
            #1;
        end

        // Reset in the middle of operation with five words held.
        for (int c = 0; c < 20 && model_q.size() < 5; c++)
            drive_cycle(1'b1, 8'($urandom), 1'b0, pu, po);
        drive_cycle(1'b0, '0, 1'b0, pu, po);
        check("mr_count_before", 32'(bus.count), 32'd5);
        do_reset(1);
        single_word(8'h3C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bram_fifo_ctrl.md
Name: bram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sequences the team's two-port block RAM, mem2p_sw_sr: synchronous write port 1, synchronous read port 2, one-cycle registered read.
- Converts the RAM into a valid/ready streaming FIFO.
- Hides the one-cycle read latency with a 2-entry prefetch output stage, so a continuously ready consumer sees one word per cycle.
- Sits between a producer and a consumer stream anywhere buffering deeper than registers is needed.

Parameters:
- W, 8, data width in bits.
- D, 128, RAM depth in words; power of 2, >= 4.
- AW (localparam), $clog2(D), RAM address width.
- CW (localparam), $clog2(D+3), width of the total-occupancy count.

Ports:
- clk  input  1  single clock, all state on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  controller accepts a word this cycle; push = in_valid & in_ready.
- in_data  input  W  write data.
- out_valid  output  1  out_data holds the FIFO head.
- out_ready  input  1  consumer takes the head; pop = out_valid & out_ready.
- out_data  output  W  head word.
- count  output  CW  total words held (RAM + in flight + output stage), 0..D+2.
- empty  output  1  count == 0.

Behaviour:
- Reset: wr_ptr = rd_ptr = 0, mem_cnt = 0, in-flight flag = 0, output stage empty.
  - Outputs after reset: out_valid=0, in_ready=1, count=0, empty=1, out_data=0.
  - Reset mid-operation discards all contents. RAM contents are not cleared.
- Write side:
  - push drives we1=1, addr1=wr_ptr, din1=in_data.
  - wr_ptr increments modulo D, wrapping naturally at D-1 -> 0.
- in_ready = (mem_cnt != D), from registered state only. No combinational path from out_ready or in_valid.
- Read side:
  - Occupancy o = output-stage entries + in-flight read (0..2).
  - Issue a read (addr2=rd_ptr, rd_ptr++ mod D, in-flight set) when mem_cnt != 0 and (o - pop) < 2.
  - mem_cnt is the registered value, excluding a same-cycle push. This guarantees a read never targets the address being written in the same cycle, so RAM read-during-write semantics are irrelevant.
  - The in-flight read's dout2 is captured into the output stage on the following cycle.
- mem_cnt update: +1 on push, -1 on read issue, unchanged when both occur.
- Output stage:
  - 2-entry FIFO of registers. out_data/out_valid come from the entry at its head.
  - Order is strictly preserved.
  - Simultaneous capture and pop is legal when the stage holds 1 or 2 entries.
- Latency: a push into a completely empty controller at cycle t gives out_valid=1 at cycle t+3.
  - t: write.
  - t+1: read issue.
  - t+2: dout2 valid, captured.
  - t+3: out_valid=1.
- Throughput: with out_ready held high and a continuous push stream, pop rate after the fill is 1 word/cycle.
- Full: mem_cnt==D forces in_ready=0. Pushes are refused even if a pop occurs the same cycle; in_ready rises the cycle after the next read issue. Total capacity is D+2.
- Empty: out_valid=0, and out_data holds its last value.
- Simultaneous push and pop in any non-full state: both take effect and count is unchanged.
- count updates every cycle as +push -pop.

Decomposition:
- Package bram_fifo_pkg:
  - occupancy type for the output stage (2-bit);
  - helper function for pointer increment modulo D.
- Instantiate mem2p_sw_sr #(W,D) for storage.
- One natural sub-module: fifo_skid2, the 2-entry output register stage with valid/ready on both sides.
- Pointer and count logic stays in the top module.

Test Plan:
- Test configuration: W=8, D=4.
- Reset check: assert rst for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, count=0, empty=1. No push is accepted while rst=1.
- Single word: push 0xA5 at cycle t into the empty FIFO -> out_valid=1 with out_data=0xA5 at t+3. Pop at t+3 -> empty=1 at t+4.
- Fill to capacity: out_ready=0, push 0x01..0x07 back-to-back.
  - Six words are accepted, count=6 (D+2).
  - in_ready=0 from the cycle count reaches 6; 0x07 is held.
  - Then out_ready=1 -> words pop in order 0x01..0x07 with no duplicates and no loss.
- Streaming: in_valid=1 and out_ready=1 continuously with an incrementing pattern for 20 words -> after the first word, one pop per cycle, data strictly incrementing, pointers wrap past 3 -> 0 several times.
- Random backpressure: random in_valid and out_ready over 1000 cycles, checked against a scoreboard queue.
  - Every popped word matches the queue head.
  - count equals the model count every cycle.
  - in_ready never depends on same-cycle out_ready.
- Reset mid-operation: with count=5, pulse rst for 1 cycle -> next cycle count=0, out_valid=0, in_ready=1. A subsequent push of 0x3C emerges 3 cycles later with no stale data.
